// File: rtl/tm1637_tx.sv
// TM1637 two-wire byte engine: START, 8 data bits LSB-first, ACK clock, optional HOLD
// between bytes of a frame, and STOP, driven from a byte-wide valid/ready handshake.
module tm1637_tx #(
    parameter int unsigned HALF_PERIOD = 100
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tm1637_clk,
    output logic       tm1637_dio,
    output logic       dio_oe,
    input  logic       dio_in,
    output logic       byte_done,
    output logic       ack_err,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_BIT_L,
        S_BIT_H,
        S_ACK_L,
        S_ACK_H,
        S_HOLD,
        S_STOP_0,
        S_STOP_1,
        S_STOP_2
    } state_t;

    localparam logic [15:0] PH_LAST = 16'(HALF_PERIOD - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        last_q, last_d;
    logic        clk_q, clk_d;
    logic        dio_q, dio_d;
    logic        oe_q, oe_d;
    logic        byte_done_q, byte_done_d;
    logic        ack_err_q, ack_err_d;
    logic        frame_done_q, frame_done_d;
    logic        dio_meta_q, dio_sync_q;

    logic        accept;
    logic        phase_end;
    logic        clk_tgt, dio_tgt, oe_tgt;

    assign tx_ready   = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign accept     = tx_valid && tx_ready;
    assign phase_end  = (cnt_q == PH_LAST);

    assign tm1637_clk = clk_q;
    assign tm1637_dio = dio_q;
    assign dio_oe     = oe_q;
    assign byte_done  = byte_done_q;
    assign ack_err    = ack_err_q;
    assign frame_done = frame_done_q;

    // The pad readback is asynchronous to clk_50M.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            dio_meta_q <= 1'b1;
            dio_sync_q <= 1'b1;
        end else begin
            dio_meta_q <= dio_in;
            dio_sync_q <= dio_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        last_d       = last_q;
        ack_err_d    = ack_err_q;
        byte_done_d  = 1'b0;
        frame_done_d = 1'b0;

        if ((state_q != S_IDLE) && (state_q != S_HOLD)) begin
            cnt_d = phase_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    last_d  = tx_last;
                    cnt_d   = 16'd0;
                end
            end
            S_START: begin
                if (phase_end) begin
                    state_d = S_BIT_L;
                    bit_d   = 3'd0;
                end
            end
            S_BIT_L: begin
                if (phase_end) begin
                    state_d = S_BIT_H;
                end
            end
            S_BIT_H: begin
                if (phase_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_ACK_L;
                    end else begin
                        state_d = S_BIT_L;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_ACK_L: begin
                if (phase_end) begin
                    state_d = S_ACK_H;
                end
            end
            S_ACK_H: begin
                if (phase_end) begin
                    ack_err_d   = dio_sync_q;
                    byte_done_d = 1'b1;
                    state_d     = last_q ? S_STOP_0 : S_HOLD;
                end
            end
            S_HOLD: begin
                // Next byte of the same frame: no repeated START.
                if (accept) begin
                    state_d = S_BIT_L;
                    bit_d   = 3'd0;
                    shift_d = tx_data;
                    last_d  = tx_last;
                    cnt_d   = 16'd0;
                end
            end
            S_STOP_0: begin
                if (phase_end) begin
                    state_d = S_STOP_1;
                end
            end
            S_STOP_1: begin
                if (phase_end) begin
                    state_d = S_STOP_2;
                end
            end
            S_STOP_2: begin
                if (phase_end) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_comb begin
        clk_tgt = 1'b1;
        dio_tgt = 1'b1;
        oe_tgt  = 1'b1;
        case (state_d)
            S_IDLE:   begin clk_tgt = 1'b1; dio_tgt = 1'b1;            oe_tgt = 1'b1; end
            S_START:  begin clk_tgt = 1'b1; dio_tgt = 1'b0;            oe_tgt = 1'b1; end
            S_BIT_L:  begin clk_tgt = 1'b0; dio_tgt = shift_d[bit_d];  oe_tgt = 1'b1; end
            S_BIT_H:  begin clk_tgt = 1'b1; dio_tgt = shift_d[bit_d];  oe_tgt = 1'b1; end
            S_ACK_L:  begin clk_tgt = 1'b0; dio_tgt = 1'b1;            oe_tgt = 1'b0; end
            S_ACK_H:  begin clk_tgt = 1'b1; dio_tgt = 1'b1;            oe_tgt = 1'b0; end
            S_HOLD:   begin clk_tgt = 1'b0; dio_tgt = 1'b0;            oe_tgt = 1'b1; end
            S_STOP_0: begin clk_tgt = 1'b0; dio_tgt = 1'b0;            oe_tgt = 1'b1; end
            S_STOP_1: begin clk_tgt = 1'b1; dio_tgt = 1'b0;            oe_tgt = 1'b1; end
            S_STOP_2: begin clk_tgt = 1'b1; dio_tgt = 1'b1;            oe_tgt = 1'b1; end
            default:  begin clk_tgt = 1'b1; dio_tgt = 1'b1;            oe_tgt = 1'b1; end
        endcase

        // A CLK edge freezes DIO/OE for one cycle so the data lines never move with CLK.
        clk_d = clk_tgt;
        if (clk_tgt != clk_q) begin
            dio_d = dio_q;
            oe_d  = oe_q;
        end else begin
            dio_d = dio_tgt;
            oe_d  = oe_tgt;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            bit_q        <= 3'd0;
            last_q       <= 1'b0;
            clk_q        <= 1'b1;
            dio_q        <= 1'b1;
            oe_q         <= 1'b1;
            byte_done_q  <= 1'b0;
            ack_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            last_q       <= last_d;
            clk_q        <= clk_d;
            dio_q        <= dio_d;
            oe_q         <= oe_d;
            byte_done_q  <= byte_done_d;
            ack_err_q    <= ack_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk_50M) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_tm1637_tx.sv
// Bench for tm1637_tx: a bus decoder rebuilds bytes, ACK clocks, START/STOP and timing
// from the pins, and each frame is compared with what the bench offered.
module tb_tm1637_tx;

    localparam int HP = 4;

    logic       clk_50M = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       tm1637_clk;
    logic       tm1637_dio;
    logic       dio_oe;
    logic       dio_in;
    logic       byte_done;
    logic       ack_err;
    logic       frame_done;
    logic       busy;

    tm1637_tx #(.HALF_PERIOD(HP)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tm1637_clk (tm1637_clk),
        .tm1637_dio (tm1637_dio),
        .dio_oe     (dio_oe),
        .dio_in     (dio_in),
        .byte_done  (byte_done),
        .ack_err    (ack_err),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial forever #5 clk_50M = ~clk_50M;

    int cyc = 0;
    initial forever begin
        @(posedge clk_50M);
        cyc++;
    end

    // Pad model: the display pulls DIO low for ACK, or leaves it high for NACK.
    logic ack_drive = 1'b0;
    assign dio_in = dio_oe ? tm1637_dio : ack_drive;

    int         acc_cyc_q[$];
    logic [7:0] acc_dat_q[$];
    bit         acc_first_q[$];
    logic       exp_ack_q[$];
    logic       ack_plan[$];
    logic [7:0] rx_q[$];
    int         bd_cyc_q[$];
    logic       bd_err_q[$];
    int         fd_cyc_q[$];
    int         starts = 0, stops = 0;
    int         coinc = 0, ready_bad = 0, hold_bad = 0;
    int         checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus observer, sampled on the falling edge.
    initial begin
        logic       pclk, pdio, poe, prst;
        logic       pb, pbv, pend, pend_last, hold_prev;
        logic [7:0] shreg;
        int         nb;
        prst = 1'b0; pend = 1'b0; pend_last = 1'b0; hold_prev = 1'b0;
        pbv = 1'b0; pb = 1'b0; nb = 0; shreg = 8'h00;
        pclk = 1'b1; pdio = 1'b1; poe = 1'b1;
        forever begin
            @(negedge clk_50M);
            if (!prst) begin
                nb  = 0;
                pbv = 1'b0;
            end else begin
                if ((tm1637_clk != pclk) && ((tm1637_dio != pdio) || (dio_oe != poe)))
                    coinc++;
                if (tm1637_clk && pclk && (tm1637_dio != pdio)) begin
                    if (!tm1637_dio) begin
                        starts++;
                        nb = 0;
                    end else begin
                        stops++;
                    end
                    pbv = 1'b0;
                end
                if (tm1637_clk && !pclk) begin
                    if (dio_oe) begin
                        pb  = tm1637_dio;
                        pbv = 1'b1;
                    end else begin
                        if (nb == 8) rx_q.push_back(shreg);
                        nb = 0;
                    end
                end
                if (!tm1637_clk && pclk && pbv) begin
                    if (nb < 8) shreg[nb] = pb;
                    nb++;
                    pbv = 1'b0;
                end
            end
            if (byte_done === 1'b1) begin
                bd_cyc_q.push_back(cyc);
                bd_err_q.push_back(ack_err);
            end
            if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
            if (!rst_n) begin
                pend      = 1'b0;
                hold_prev = 1'b0;
            end else begin
                if ((byte_done === 1'b1) && !pend_last) pend = 1'b0;
                if (frame_done === 1'b1) pend = 1'b0;
                if (tx_ready !== !pend) ready_bad++;
                if (busy && tx_ready) begin
                    if (tm1637_clk !== 1'b0) hold_bad++;
                    if (hold_prev && ((tm1637_dio !== 1'b0) || (dio_oe !== 1'b1))) hold_bad++;
                    hold_prev = 1'b1;
                end else begin
                    hold_prev = 1'b0;
                end
                if (tx_valid && tx_ready) begin
                    pend      = 1'b1;
                    pend_last = tx_last;
                    acc_cyc_q.push_back(cyc + 1);
                    acc_dat_q.push_back(tx_data);
                    acc_first_q.push_back(!busy);
                    if (ack_plan.size() > 0) ack_drive = ack_plan.pop_front();
                    else ack_drive = 1'($urandom_range(0, 1));
                    exp_ack_q.push_back(ack_drive);
                end
            end
            pclk = tm1637_clk;
            pdio = tm1637_dio;
            poe  = dio_oe;
            prst = rst_n;
        end
    end

    task automatic clear_q();
        acc_cyc_q.delete(); acc_dat_q.delete(); acc_first_q.delete(); exp_ack_q.delete();
        ack_plan.delete(); rx_q.delete(); bd_cyc_q.delete(); bd_err_q.delete(); fd_cyc_q.delete();
        starts = 0;
        stops  = 0;
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic ack, input int gap);
        int n0;
        int k;
        for (k = 0; k < 3000; k++) begin
            if (tx_ready === 1'b1) break;
            tick();
        end
        if (k == 3000) chk("ready_timeout", 32'(tx_ready), 32'd1);
        repeat (gap) tick();
        n0 = acc_dat_q.size();
        ack_plan.push_back(ack);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = last;
        for (k = 0; k < 100; k++) begin
            tick();
            if (acc_dat_q.size() > n0) break;
        end
        if (k == 100) chk("accept_timeout", 32'(acc_dat_q.size()), 32'(n0 + 1));
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic stream_frame(input int n);
        for (int k = 0; k < 3000 && acc_dat_q.size() < n; k++) begin
            tick();
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            tx_last  = (acc_dat_q.size() == n - 1);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int k = 0; k < 3000; k++) begin
            if (fd_cyc_q.size() > 0) break;
            tick();
        end
        if (fd_cyc_q.size() == 0) chk({tag, "_frame_timeout"}, 32'(fd_cyc_q.size()), 32'd1);
        tick();
    endtask

    // A byte started from IDLE takes START + 16 bit phases + 2 ACK phases; from HOLD
    // there is no START. STOP adds three phases before frame_done.
    task automatic check_frame(input string tag);
        int n;
        n = acc_dat_q.size();
        chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_q[i]), 32'(acc_dat_q[i]));
        chk({tag, "_byte_done_count"}, 32'(bd_cyc_q.size()), 32'(n));
        for (int i = 0; i < n && i < bd_cyc_q.size(); i++) begin
            chk($sformatf("%s_ack_err%0d", tag, i), 32'(bd_err_q[i]), 32'(exp_ack_q[i]));
            chk($sformatf("%s_byte_done_time%0d", tag, i), 32'(bd_cyc_q[i]),
                32'(acc_cyc_q[i] + (acc_first_q[i] ? 19 : 18) * HP));
        end
        chk({tag, "_frame_done_count"}, 32'(fd_cyc_q.size()), 32'd1);
        if (fd_cyc_q.size() > 0 && n > 0)
            chk({tag, "_frame_done_time"}, 32'(fd_cyc_q[0]),
                32'(acc_cyc_q[n-1] + (acc_first_q[n-1] ? 22 : 21) * HP));
        chk({tag, "_starts"}, 32'(starts), 32'd1);
        chk({tag, "_stops"}, 32'(stops), 32'd1);
        chk({tag, "_idle_pins"}, 32'({tm1637_clk, tm1637_dio, dio_oe, busy, tx_ready}), 32'b11101);
    endtask

    initial begin
        int a;
        int n;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_clk", 32'(tm1637_clk), 32'd1);
        chk("rst_dio", 32'(tm1637_dio), 32'd1);
        chk("rst_oe", 32'(dio_oe), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_byte_done", 32'(byte_done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Single byte 0x40 with ACK.
        clear_q();
        send_byte(8'h40, 1'b1, 1'b0, 2);
        wait_frame("s1");
        check_frame("s1");
        if (rx_q.size() > 0) chk("s1_byte40", 32'(rx_q[0]), 32'h40);
        if (fd_cyc_q.size() > 0 && acc_cyc_q.size() > 0)
            chk("s1_latency", 32'(fd_cyc_q[0] - acc_cyc_q[0] + 1), 32'd89);

        // Three-byte frame with a 10-cycle HOLD dwell.
        clear_q();
        send_byte(8'hC0, 1'b0, 1'b0, 0);
        send_byte(8'h3F, 1'b0, 1'b0, 10);
        send_byte(8'h06, 1'b1, 1'b0, 0);
        wait_frame("s2");
        check_frame("s2");

        // NACK does not abort the frame.
        clear_q();
        send_byte(8'h8F, 1'b1, 1'b1, 3);
        wait_frame("s3");
        check_frame("s3");
        chk("s3_ack_err_held", 32'(ack_err), 32'd1);

        // tx_valid held high with data changing every cycle.
        clear_q();
        stream_frame(3);
        wait_frame("s4");
        check_frame("s4");

        // Reset during the high phase of bit 3.
        clear_q();
        send_byte(8'($urandom), 1'b1, 1'b0, 1);
        a = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : cyc;
        for (int k = 0; k < 500 && cyc < a + 8 * HP + 1; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s5_pins", 32'({tm1637_clk, tm1637_dio, dio_oe}), 32'b111);
        chk("s5_ready", 32'(tx_ready), 32'd1);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_dones", 32'({byte_done, frame_done}), 32'd0);
        repeat (100) tick();
        chk("s5_no_byte_done", 32'(bd_cyc_q.size()), 32'd0);
        chk("s5_no_frame_done", 32'(fd_cyc_q.size()), 32'd0);
        clear_q();
        send_byte(8'($urandom), 1'b0, 1'b1, 0);
        send_byte(8'($urandom), 1'b1, 1'b0, 2);
        wait_frame("s5b");
        check_frame("s5b");

        // Random frames.
        for (int f = 0; f < 5; f++) begin
            clear_q();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++)
                send_byte(8'($urandom), (i == n - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            wait_frame($sformatf("r%0d", f));
            check_frame($sformatf("r%0d", f));
        end

        chk("coincident_edges", 32'(coinc), 32'd0);
        chk("ready_outside_idle_hold", 32'(ready_bad), 32'd0);
        chk("hold_pins", 32'(hold_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm1637_tx.md
Name: tm1637_tx

Overview:
- Serial byte engine for the TM1637 two-wire bus; the stage directly downstream of the ROM step sequencer.
- Replaces the generic SPI master's DIO mode.
- Takes bytes from the sequencer over a valid/ready handshake. Generates START, 8 data bits LSB-first, the ACK clock and STOP on tm1637_clk/tm1637_dio.
- Reports per-byte ACK status and frame completion back to the sequencer.

Parameters:
HALF_PERIOD, 100, clk_50M cycles per half bit period (one bus phase); legal range 4..65535; 100 gives 250 kHz bit rate.

Ports:
clk_50M  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset, sampled on posedge clk_50M
tx_valid  in  1  byte offered by sequencer
tx_data  in  8  byte to send, captured on acceptance
tx_last  in  1  byte is the last of its frame (STOP follows), captured with tx_data
tx_ready  out  1  engine can accept a byte this cycle
tm1637_clk  out  1  bus CLK, registered
tm1637_dio  out  1  bus DIO drive value, registered
dio_oe  out  1  1 = drive tm1637_dio, 0 = release the pad for ACK
dio_in  in  1  DIO pad readback, asynchronous
byte_done  out  1  one-cycle pulse after each byte's ACK sample
ack_err  out  1  sampled DIO at ACK: 1 = NACK; valid while byte_done=1, held otherwise
frame_done  out  1  one-cycle pulse when STOP completes
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a posedge) forces, the following cycle:
  - state=IDLE; tm1637_clk=1, tm1637_dio=1, dio_oe=1.
  - tx_ready=1, busy=0, byte_done=0, ack_err=0, frame_done=0.
  - Phase counter=0. Any in-flight byte is dropped with no done pulses.
  - Reset has priority over every other event.
- dio_in passes through a 2-flop synchronizer. ACK logic uses only the synchronized value.
- Phase counter:
  - Counts 0..HALF_PERIOD-1; each state/phase lasts exactly HALF_PERIOD cycles unless noted.
  - Counter clears on every phase change.
- Acceptance: tx_valid && tx_ready at a posedge. tx_data and tx_last are latched into a shift register and a last flag. tx_ready is 1 only in IDLE and HOLD.
- States (outputs listed as CLK/DIO/OE):
  - IDLE: 1/1/1. On accept, go to START.
  - START: 1/0/1 for HALF_PERIOD. DIO falls while CLK is high, one cycle after acceptance. Then go to BIT_L with bit index 0.
  - BIT_L: 0/shift[i]/1. DIO changes only on entry, with CLK low.
  - BIT_H: 1/shift[i]/1. After index 7 go to ACK_L; otherwise increment the index and go to BIT_L.
  - ACK_L: 0/1/0 (released).
  - ACK_H: 1/1/0. On the last cycle of the phase, sample synchronized DIO into ack_err; byte_done pulses the next cycle.
  - After ACK_H: go to STOP_0 if the last flag is set, otherwise to HOLD.
  - HOLD: 0/0/1, tx_ready=1, no time limit.
    - On accept, go straight to BIT_L, index 0; no new START.
    - Acceptance in the first HOLD cycle is legal.
  - STOP_0: 0/0/1.
  - STOP_1: 1/0/1.
  - STOP_2: 1/1/1. DIO rises while CLK is high. Then go to IDLE; frame_done=1 in the first IDLE cycle, the same cycle tx_ready returns to 1.
- NACK does not abort; the frame continues. The sequencer decides on retry.
- Single-byte frame duration: acceptance edge to frame_done = 22*HALF_PERIOD+1 cycles.
- Each extra byte adds 18*HALF_PERIOD cycles plus the HOLD dwell (min 1 cycle).
- tx_valid while tx_ready=0 is ignored; upstream must hold tx_valid.
- tx_data/tx_last may change freely after acceptance.
- tm1637_clk never changes in the same cycle as tm1637_dio or dio_oe, except on the reset-forced return to idle.

Test Plan:
- HALF_PERIOD=4, reset, then tx_valid=1, tx_data=8'h40, tx_last=1 -> START and 8 CLK pulses. DIO in BIT_H phases reads 0,0,0,0,0,0,1,0. dio_in=0 at ACK gives byte_done with ack_err=0. frame_done exactly 89 cycles after the acceptance edge; idle 1/1/1.
- Frame 8'hC0 (tx_last=0), then 8'h3F after 10 HOLD cycles, 8'h06 tx_last=1 -> one START and one STOP only. CLK stays low and DIO=0 during HOLD. Three byte_done pulses, one frame_done.
- dio_in held 1 through ACK of byte 8'h8F -> ack_err=1 with byte_done. STOP still issued; frame_done pulses.
- tx_valid asserted continuously mid-frame with changing tx_data -> only the value present at each acceptance edge is transmitted. tx_ready=0 outside IDLE/HOLD.
- rst_n=0 for one cycle during BIT_H of bit 3 -> next cycle 1/1/1 outputs, tx_ready=1, no byte_done/frame_done. A new frame then transmits correctly.
- Checker across all scenarios: no CLK edge coincides with a DIO/OE edge; DIO transitions while CLK=1 occur only in START and STOP_2.
